// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage. Registers the EX/MEM bundle into MEM/WB,
// runs loads/stores over a req/ack data port, stalls upstream while an access
// is outstanding, and exports combinational forwarding for the incoming
// instruction.
//
// Handshake: mem_req rises on the edge that accepts an aligned access and stays
// high, with we/addr/be/wdata frozen, until the edge that samples mem_ack=1.
// mem_ack is a single-cycle pulse; it is only honoured in ACCESS. Upstream must
// hold ex_mem_* whenever mem_stall=1; those held inputs are taken in the first
// IDLE cycle after the ack.
module memory_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        ex_mem_regdest,
  input  logic              ex_mem_writereg,
  input  logic [31:0]       ex_mem_wbvalue,
  input  logic [31:0]       ex_mem_wdata,
  input  logic              ex_mem_readmem,
  input  logic              ex_mem_writemem,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_signext,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_stall,
  output logic              mem_misaligned,
  output logic [4:0]        mem_wb_regdest,
  output logic              mem_wb_writereg,
  output logic [31:0]       mem_wb_wbvalue,
  output logic              mem_fw_writereg,
  output logic [4:0]        mem_fw_regdest,
  output logic [31:0]       mem_fw_wbvalue
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              misaligned_q, misaligned_d;
  logic [4:0]        wb_regdest_q, wb_regdest_d;
  logic              wb_writereg_q, wb_writereg_d;
  logic [31:0]       wb_wbvalue_q, wb_wbvalue_d;
  logic [4:0]        lat_regdest_q, lat_regdest_d;
  logic              lat_writereg_q, lat_writereg_d;
  logic [1:0]        lat_size_q, lat_size_d;
  logic              lat_signext_q, lat_signext_d;
  logic [1:0]        lat_a_q, lat_a_d;

  // Decoded view of the incoming access.
  logic [1:0]  in_a;
  logic        in_is_mem;
  logic        in_mis;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  // Load data extracted from the ack-cycle read data.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  // Lane decode: byte enables, misalignment and replicated store data.
  always_comb begin
    in_a      = ex_mem_wbvalue[1:0];
    in_is_mem = ex_mem_readmem | ex_mem_writemem;
    in_mis    = 1'b0;
    in_be     = 4'b1111;
    in_wdata  = ex_mem_wdata;
    case (ex_mem_size)
      2'b00: begin
        in_be    = 4'b0001 << in_a;
        in_wdata = {4{ex_mem_wdata[7:0]}};
      end
      2'b01: begin
        in_mis   = in_a[0];
        in_be    = in_a[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{ex_mem_wdata[15:0]}};
      end
      default: begin
        in_mis   = |in_a;
        in_be    = 4'b1111;
        in_wdata = ex_mem_wdata;
      end
    endcase
  end

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    rd_byte  = mem_rdata[{lat_a_q, 3'b000} +: 8];
    rd_half  = lat_a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (lat_size_q)
      2'b00:   load_val = {{24{lat_signext_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{lat_signext_q & rd_half[15]}}, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state and next-register logic; MEM/WB defaults to a bubble.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    misaligned_d   = 1'b0;
    wb_regdest_d   = 5'd0;
    wb_writereg_d  = 1'b0;
    wb_wbvalue_d   = 32'd0;
    lat_regdest_d  = lat_regdest_q;
    lat_writereg_d = lat_writereg_q;
    lat_size_d     = lat_size_q;
    lat_signext_d  = lat_signext_q;
    lat_a_d        = lat_a_q;
    case (state_q)
      IDLE: begin
        if (in_is_mem && !in_mis) begin
          lat_regdest_d  = ex_mem_regdest;
          lat_writereg_d = ex_mem_writereg;
          lat_size_d     = ex_mem_size;
          lat_signext_d  = ex_mem_signext;
          lat_a_d        = in_a;
          req_d          = 1'b1;
          we_d           = ex_mem_writemem;
          addr_d         = {ex_mem_wbvalue[ADDR_W-1:2], 2'b00};
          be_d           = in_be;
          wdata_d        = in_wdata;
          state_d        = ACCESS;
        end else if (in_is_mem) begin
          // Misaligned: drop the access, leave a bubble, raise the flag.
          misaligned_d = 1'b1;
        end else begin
          wb_regdest_d  = ex_mem_regdest;
          wb_writereg_d = ex_mem_writereg;
          wb_wbvalue_d  = ex_mem_wbvalue;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            wb_regdest_d  = lat_regdest_q;
            wb_writereg_d = lat_writereg_q;
            wb_wbvalue_d  = load_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= 32'd0;
      be_q           <= 4'd0;
      misaligned_q   <= 1'b0;
      wb_regdest_q   <= 5'd0;
      wb_writereg_q  <= 1'b0;
      wb_wbvalue_q   <= 32'd0;
      lat_regdest_q  <= 5'd0;
      lat_writereg_q <= 1'b0;
      lat_size_q     <= 2'd0;
      lat_signext_q  <= 1'b0;
      lat_a_q        <= 2'd0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      misaligned_q   <= misaligned_d;
      wb_regdest_q   <= wb_regdest_d;
      wb_writereg_q  <= wb_writereg_d;
      wb_wbvalue_q   <= wb_wbvalue_d;
      lat_regdest_q  <= lat_regdest_d;
      lat_writereg_q <= lat_writereg_d;
      lat_size_q     <= lat_size_d;
      lat_signext_q  <= lat_signext_d;
      lat_a_q        <= lat_a_d;
    end
  end

  // Registered outputs, stall from state, and forwarding of the incoming op.
  always_comb begin
    mem_req         = req_q;
    mem_we          = we_q;
    mem_addr        = addr_q;
    mem_wdata       = wdata_q;
    mem_be          = be_q;
    mem_misaligned  = misaligned_q;
    mem_stall       = (state_q == ACCESS);
    mem_wb_regdest  = wb_regdest_q;
    mem_wb_writereg = wb_writereg_q;
    mem_wb_wbvalue  = wb_wbvalue_q;
    mem_fw_writereg = ex_mem_writereg & ~ex_mem_readmem & (state_q == IDLE);
    mem_fw_regdest  = ex_mem_regdest;
    mem_fw_wbvalue  = ex_mem_wbvalue;
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: table-driven vectors for memory_stage plus hand sequences
// for the held-input and reset-during-access cases.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ex_mem_regdest;
  logic        ex_mem_writereg;
  logic [31:0] ex_mem_wbvalue;
  logic [31:0] ex_mem_wdata;
  logic        ex_mem_readmem;
  logic        ex_mem_writemem;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_signext;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_stall;
  logic        mem_misaligned;
  logic [4:0]  mem_wb_regdest;
  logic        mem_wb_writereg;
  logic [31:0] mem_wb_wbvalue;
  logic        mem_fw_writereg;
  logic [4:0]  mem_fw_regdest;
  logic [31:0] mem_fw_wbvalue;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {compare_all, writereg, regdest, wbvalue}
  logic [38:0] exp_q[$];

  typedef struct {
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] val;
    logic [31:0] wdata;
    logic        rmem;
    logic        wmem;
    logic [1:0]  size;
    logic        sext;
    int          delay;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[14];

  memory_stage #(.ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
    .ex_mem_wbvalue(ex_mem_wbvalue), .ex_mem_wdata(ex_mem_wdata),
    .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
    .ex_mem_size(ex_mem_size), .ex_mem_signext(ex_mem_signext),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_stall(mem_stall), .mem_misaligned(mem_misaligned),
    .mem_wb_regdest(mem_wb_regdest), .mem_wb_writereg(mem_wb_writereg),
    .mem_wb_wbvalue(mem_wb_wbvalue), .mem_fw_writereg(mem_fw_writereg),
    .mem_fw_regdest(mem_fw_regdest), .mem_fw_wbvalue(mem_fw_wbvalue)
  );

  // Clock
  always #5 clock = ~clock;

  function automatic vec_t mk(
    input logic [4:0] rd, input logic wr, input logic [31:0] val,
    input logic [31:0] wdata, input logic rmem, input logic wmem,
    input logic [1:0] size, input logic sext, input int delay,
    input logic [31:0] rdata, input logic exp_mis, input logic [3:0] exp_be,
    input logic [31:0] exp_mwdata, input logic [31:0] exp_val);
    vec_t v;
    v.rd = rd; v.wr = wr; v.val = val; v.wdata = wdata;
    v.rmem = rmem; v.wmem = wmem; v.size = size; v.sext = sext;
    v.delay = delay; v.rdata = rdata; v.exp_mis = exp_mis;
    v.exp_be = exp_be; v.exp_mwdata = exp_mwdata; v.exp_val = exp_val;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic wr, input logic [31:0] val,
                       input logic [31:0] wdata, input logic rmem, input logic wmem,
                       input logic [1:0] size, input logic sext);
    ex_mem_regdest  = rd;
    ex_mem_writereg = wr;
    ex_mem_wbvalue  = val;
    ex_mem_wdata    = wdata;
    ex_mem_readmem  = rmem;
    ex_mem_writemem = wmem;
    ex_mem_size     = size;
    ex_mem_signext  = sext;
  endtask

  task automatic drive_nop();
    drive(5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Pop the next expected writeback and compare against mem_wb_*.
  task automatic check_wb(input string name);
    logic [38:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_q_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_wb_writereg"}, {31'd0, mem_wb_writereg}, {31'd0, e[37]});
      if (e[38]) begin
        chk({name, "_wb_regdest"}, {27'd0, mem_wb_regdest}, {27'd0, e[36:32]});
        chk({name, "_wb_wbvalue"}, mem_wb_wbvalue, e[31:0]);
      end
    end
  endtask

  // Apply one vector from IDLE (called #1 after a posedge) and follow it
  // until its writeback appears.
  task automatic run_vec(input vec_t v, input string name);
    logic is_mem;
    is_mem = v.rmem | v.wmem;
    drive(v.rd, v.wr, v.val, v.wdata, v.rmem, v.wmem, v.size, v.sext);
    #1;
    chk({name, "_fw_writereg"}, {31'd0, mem_fw_writereg}, {31'd0, v.wr & ~v.rmem});
    chk({name, "_fw_regdest"}, {27'd0, mem_fw_regdest}, {27'd0, v.rd});
    chk({name, "_fw_wbvalue"}, mem_fw_wbvalue, v.val);
    if (v.exp_mis)    exp_q.push_back({1'b1, 1'b0, 5'd0, 32'd0});
    else if (!is_mem) exp_q.push_back({1'b1, v.wr, v.rd, v.exp_val});
    else if (v.wmem)  exp_q.push_back({1'b0, 1'b0, v.rd, 32'd0});
    else              exp_q.push_back({1'b1, v.wr, v.rd, v.exp_val});
    @(posedge clock); #1;
    drive_nop();
    if (!is_mem) begin
      check_wb(name);
      chk({name, "_stall"}, {31'd0, mem_stall}, 32'd0);
      chk({name, "_req"}, {31'd0, mem_req}, 32'd0);
    end else if (v.exp_mis) begin
      chk({name, "_misaligned"}, {31'd0, mem_misaligned}, 32'd1);
      chk({name, "_req"}, {31'd0, mem_req}, 32'd0);
      chk({name, "_stall"}, {31'd0, mem_stall}, 32'd0);
      check_wb(name);
      @(posedge clock); #1;
      chk({name, "_misaligned_clear"}, {31'd0, mem_misaligned}, 32'd0);
    end else begin
      chk({name, "_req"}, {31'd0, mem_req}, 32'd1);
      chk({name, "_we"}, {31'd0, mem_we}, {31'd0, v.wmem});
      chk({name, "_addr"}, mem_addr, {v.val[31:2], 2'b00});
      chk({name, "_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
      chk({name, "_wdata"}, mem_wdata, v.exp_mwdata);
      chk({name, "_stall"}, {31'd0, mem_stall}, 32'd1);
      chk({name, "_bubble"}, {31'd0, mem_wb_writereg}, 32'd0);
      for (int i = 0; i < v.delay; i++) begin
        mem_rdata = $urandom;
        @(posedge clock); #1;
        chk({name, "_wait_stall"}, {31'd0, mem_stall}, 32'd1);
        chk({name, "_wait_req"}, {31'd0, mem_req}, 32'd1);
        chk({name, "_wait_bubble"}, {31'd0, mem_wb_writereg}, 32'd0);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(posedge clock); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      check_wb(name);
      chk({name, "_done_stall"}, {31'd0, mem_stall}, 32'd0);
      chk({name, "_done_req"}, {31'd0, mem_req}, 32'd0);
    end
  endtask

  initial begin
    vec_t rv;
    // Vector table
    vecs[0]  = mk(5'd2,  1'b1, 32'hFFFFA0EE, 32'h0,        1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0,        1'b0, 4'h0, 32'h0,        32'hFFFFA0EE);
    vecs[1]  = mk(5'd8,  1'b1, 32'h00000010, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 2, 32'h07E8A0EE, 1'b0, 4'hF, 32'h0,        32'h07E8A0EE);
    vecs[2]  = mk(5'd5,  1'b1, 32'h00000003, 32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 0, 32'h80FFFFFF, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80);
    vecs[3]  = mk(5'd5,  1'b1, 32'h00000003, 32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 1, 32'h80FFFFFF, 1'b0, 4'h8, 32'h0,        32'h00000080);
    vecs[4]  = mk(5'd9,  1'b1, 32'h00000006, 32'h0000A0AB, 1'b0, 1'b1, 2'd1, 1'b0, 1, 32'h0,        1'b0, 4'hC, 32'hA0ABA0AB, 32'h0);
    vecs[5]  = mk(5'd6,  1'b1, 32'h00000002, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0);
    vecs[6]  = mk(5'd10, 1'b1, 32'h00000002, 32'h0,        1'b1, 1'b0, 2'd1, 1'b1, 1, 32'h80011234, 1'b0, 4'hC, 32'h0,        32'hFFFF8001);
    vecs[7]  = mk(5'd11, 1'b0, 32'h00000001, 32'h000000C5, 1'b0, 1'b1, 2'd0, 1'b0, 0, 32'h0,        1'b0, 4'h2, 32'hC5C5C5C5, 32'h0);
    vecs[8]  = mk(5'd12, 1'b0, 32'h00000020, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2, 1'b0, 3, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0);
    vecs[9]  = mk(5'd13, 1'b0, 32'h00000001, 32'h00001234, 1'b0, 1'b1, 2'd1, 1'b0, 0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0);
    vecs[10] = mk(5'd3,  1'b0, 32'h12345678, 32'h0,        1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h12345678);
    vecs[11] = mk(5'd14, 1'b1, 32'h00000044, 32'h0,        1'b1, 1'b0, 2'd3, 1'b1, 0, 32'hCAFEF00D, 1'b0, 4'hF, 32'h0,        32'hCAFEF00D);
    vecs[12] = mk(5'd15, 1'b1, 32'h00000000, 32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 0, 32'h12348765, 1'b0, 4'h3, 32'h0,        32'h00008765);
    vecs[13] = mk(5'd16, 1'b1, 32'h00000001, 32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 0, 32'h00007F00, 1'b0, 4'h2, 32'h0,        32'h0000007F);

    // Reset
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    drive_nop();
    #3;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_misaligned", {31'd0, mem_misaligned}, 32'd0);
    chk("rst_wb_regdest", {27'd0, mem_wb_regdest}, 32'd0);
    chk("rst_wb_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    chk("rst_wb_wbvalue", mem_wb_wbvalue, 32'd0);
    #9 reset = 1'b0;
    @(posedge clock); #1;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Random ALU pass-throughs
    for (int i = 0; i < 4; i++) begin
      rv = mk(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 32'd0, $urandom,
              1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);
      rv.val     = $urandom;
      rv.exp_val = rv.val;
      run_vec(rv, $sformatf("alu_rand%0d", i));
    end

    // Held ALU instruction behind a load is taken after the ack.
    drive(5'd20, 1'b1, 32'h00000100, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clock); #1;
    drive(5'd7, 1'b1, 32'h11112222, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    chk("held_fw_blocked", {31'd0, mem_fw_writereg}, 32'd0);
    chk("held_stall", {31'd0, mem_stall}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5A0001;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    chk("held_load_writereg", {31'd0, mem_wb_writereg}, 32'd1);
    chk("held_load_regdest", {27'd0, mem_wb_regdest}, 32'd20);
    chk("held_load_value", mem_wb_wbvalue, 32'h5A5A0001);
    chk("held_fw_open", {31'd0, mem_fw_writereg}, 32'd1);
    @(posedge clock); #1;
    chk("held_alu_writereg", {31'd0, mem_wb_writereg}, 32'd1);
    chk("held_alu_regdest", {27'd0, mem_wb_regdest}, 32'd7);
    chk("held_alu_value", mem_wb_wbvalue, 32'h11112222);
    drive_nop();
    @(posedge clock); #1;

    // Reset in the middle of an access; a late ack must be ignored.
    drive(5'd4, 1'b1, 32'h00000030, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clock); #1;
    drive_nop();
    chk("midrst_req_before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_be", {28'd0, mem_be}, 32'd0);
    chk("midrst_wb_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    #2 reset = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hABCD1234;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    chk("late_ack_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    chk("late_ack_value", mem_wb_wbvalue, 32'd0);
    chk("late_ack_regdest", {27'd0, mem_wb_regdest}, 32'd0);
    chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);

    // Final report
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline MEM stage of the 5-stage MIPS-style core, between Execute and Writeback. It registers the EX/MEM bundle into the MEM/WB pipeline register that feeds Writeback (mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue). It performs load and store accesses on a req/ack data-memory port, and stalls upstream while an access is outstanding. It also exports forwarding values for the instruction it is currently receiving.

Parameters:
ADDR_W, 32, width of mem_addr; taken from the low ADDR_W bits of ex_mem_wbvalue.

Ports:
clock  in  1  stage clock, posedge.
reset  in  1  asynchronous, active-high.
ex_mem_regdest  in  5  destination register.
ex_mem_writereg  in  1  instruction writes a register.
ex_mem_wbvalue  in  32  ALU result; effective address for loads/stores.
ex_mem_wdata  in  32  store data (rt).
ex_mem_readmem  in  1  load.
ex_mem_writemem  in  1  store (readmem and writemem never both 1).
ex_mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
ex_mem_signext  in  1  sign-extend sub-word loads.
mem_req  out  1  memory request, registered.
mem_we  out  1  1 = write.
mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
mem_wdata  out  32  lane-replicated store data.
mem_be  out  4  byte enables, little-endian.
mem_rdata  in  32  read data, valid when mem_ack=1.
mem_ack  in  1  one-cycle completion pulse.
mem_stall  out  1  upstream must hold ex_mem_* inputs.
mem_misaligned  out  1  one-cycle flag for a misaligned access.
mem_wb_regdest  out  5  to Writeback.
mem_wb_writereg  out  1  to Writeback.
mem_wb_wbvalue  out  32  to Writeback.
mem_fw_writereg  out  1  forwarding valid, combinational.
mem_fw_regdest  out  5  forwarding register, combinational.
mem_fw_wbvalue  out  32  forwarding value, combinational.

Behaviour:
- Reset (async): state IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_stall, mem_misaligned, mem_wb_*.
- Reset during ACCESS abandons the transaction. A later mem_ack seen in IDLE is ignored.

FSM states:
- IDLE:
  - Non-memory instruction: at posedge, mem_wb_* <= {ex_mem_regdest, ex_mem_writereg, ex_mem_wbvalue}. Latency 1 cycle.
  - Aligned load/store: at posedge, latch regdest, writereg, size, signext, addr[1:0]. Drive mem_req=1, mem_we=writemem, mem_addr, mem_be, mem_wdata. Go to ACCESS. Write a bubble: mem_wb_writereg<=0, regdest/wbvalue<=0.
  - Misaligned access: no request issued, state stays IDLE, mem_wb bubble, mem_misaligned<=1 for one cycle.
- ACCESS:
  - mem_req/we/addr/be/wdata held stable.
  - mem_stall=1 for every ACCESS cycle, including the ack cycle. mem_stall is decoded from registered state only.
  - Each posedge without mem_ack writes a bubble to mem_wb.
  - Posedge with mem_ack: load writes mem_wb_writereg <= latched writereg, regdest, and the extracted value. Store writes mem_wb_writereg <= 0. mem_req <= 0, state IDLE.
  - Held ex_mem_* inputs are accepted in the following IDLE cycle.
- Load-to-result latency: 2 cycles minimum (ack in the first ACCESS cycle).

Alignment and lanes (a = addr[1:0]):
- word: a==0, be=1111.
- half: a[0]==0, be=0011 (a=0) or 1100 (a=2).
- byte: be = 0001<<a.
- Misaligned if a word has a!=0 or a half has a[0]!=0.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
- Load extract: byte = rdata[8a+7:8a]; half = rdata[16*a[1]+15:16*a[1]].
- Zero-extend, or sign-extend when signext=1.

Forwarding:
- mem_fw_writereg = ex_mem_writereg & ~ex_mem_readmem & (state==IDLE).
- mem_fw_regdest = ex_mem_regdest; mem_fw_wbvalue = ex_mem_wbvalue.
- Load results are forwarded only from the Writeback side.

Test Plan:
- ALU pass-through: regdest=2, writereg=1, wbvalue=FFFFA0EE, no mem op -> after 1 posedge mem_wb = {2, 1, FFFFA0EE}; mem_stall=0; mem_fw_writereg=1 before the edge.
- Word load, addr 00000010, ack 2 cycles after mem_req rises, rdata=07E8A0EE, regdest=8 -> mem_req=1, be=1111, addr=10; mem_stall=1 for 3 cycles; bubbles then mem_wb={8, 1, 07E8A0EE}.
- Byte load, addr 00000003, signext=1, rdata=80FFFFFF -> mem_wb_wbvalue=FFFFFF80; with signext=0 -> 00000080.
- Half store, addr 00000006, wdata=0000A0AB -> be=1100, mem_wdata=A0ABA0AB, mem_we=1; at ack mem_wb_writereg=0.
- Misaligned word load, addr 00000002 -> no mem_req, mem_misaligned=1 for 1 cycle, mem_wb_writereg=0, no stall.
- Reset asserted mid-ACCESS, then mem_ack pulsed after release -> mem_req=0 and mem_stall=0 immediately; mem_wb stays 0; late ack ignored.
